// File: rtl/print_pkg.sv
// Shared types and defaults for the print port and its FIFO.
package print_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int PRINT_DATA_W       = 16;
    localparam int PRINT_HOLD_DEFAULT = 50_000_000;
    localparam int PRINT_GAP_DEFAULT  = 10_000_000;

    // Counter width for a cycle count, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/print_fifo.sv
// Small synchronous FIFO; head word visible combinationally on pop_data.
module print_fifo #(
    parameter  int DATA_W = 16,
    parameter  int DEPTH  = 4,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       count
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              w_push_ok;
    logic              w_pop_ok;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign pop_data  = r_mem[r_rd_ptr];
    assign w_push_ok = push && !full && !flush;
    assign w_pop_ok  = pop && !empty && !flush;

    always_ff @(posedge clk) begin
        if (w_push_ok)
            r_mem[r_wr_ptr] <= push_data;
    end

    // Pointers are exactly log2(DEPTH) bits, so they wrap without compare logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/print_port.sv
// Queues CPU print words and shows each one for a fixed hold time, then a blank gap.
module print_port
    import print_pkg::*;
#(
    parameter int DATA_W      = PRINT_DATA_W,
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = PRINT_HOLD_DEFAULT,
    parameter int GAP_CYCLES  = PRINT_GAP_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              clear,
    output logic              print_signal,
    output logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              overflow
);

    localparam int HW = cnt_w(HOLD_CYCLES);
    localparam int GW = cnt_w(GAP_CYCLES);
    localparam int AW = $clog2(DEPTH);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LOAD  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t            r_state,    w_state_nxt;
    logic [HW-1:0]     r_hold_cnt, w_hold_nxt;
    logic [GW-1:0]     r_gap_cnt,  w_gap_nxt;
    logic              r_print,    w_print_nxt;
    logic [DATA_W-1:0] r_data,     w_data_nxt;
    logic              r_ovf,      w_ovf_nxt;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [DATA_W-1:0] w_head;
    logic [AW:0]       w_count;

    // wr_ready comes from occupancy before any same-edge pop: no full-FIFO bypass.
    assign wr_ready     = !w_full;
    assign w_push       = wr_en && !w_full && !clear;
    assign w_pop        = (r_state == IDLE) && !w_empty && !clear;
    assign print_signal = r_print;
    assign data         = r_data;
    assign overflow     = r_ovf;
    assign busy         = (r_state != IDLE) || (w_count != '0);

    print_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (clear),
        .push      (w_push),
        .push_data (wr_data),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        w_gap_nxt   = r_gap_cnt;
        w_print_nxt = r_print;
        w_data_nxt  = r_data;
        w_ovf_nxt   = r_ovf;
        if (clear) begin
            w_state_nxt = IDLE;
            w_hold_nxt  = '0;
            w_gap_nxt   = '0;
            w_print_nxt = 1'b0;
            w_data_nxt  = '0;
            w_ovf_nxt   = 1'b0;
        end else begin
            if (wr_en && w_full)
                w_ovf_nxt = 1'b1;
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        w_data_nxt  = w_head;
                        w_print_nxt = 1'b1;
                        w_hold_nxt  = HOLD_LOAD;
                        w_state_nxt = SHOW;
                    end
                end
                SHOW: begin
                    if (r_hold_cnt == '0) begin
                        w_print_nxt = 1'b0;
                        if (GAP_CYCLES == 0) begin
                            w_state_nxt = IDLE;
                        end else begin
                            w_gap_nxt   = GAP_LOAD;
                            w_state_nxt = GAP;
                        end
                    end else begin
                        w_hold_nxt = r_hold_cnt - HW'(1);
                    end
                end
                GAP: begin
                    if (r_gap_cnt == '0)
                        w_state_nxt = IDLE;
                    else
                        w_gap_nxt = r_gap_cnt - GW'(1);
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_hold_cnt <= '0;
            r_gap_cnt  <= '0;
            r_print    <= 1'b0;
            r_data     <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_gap_cnt  <= w_gap_nxt;
            r_print    <= w_print_nxt;
            r_data     <= w_data_nxt;
            r_ovf      <= w_ovf_nxt;
        end
    end

endmodule

// File: tb/tb_print_port.sv
// Bench for print_port: directed vector table, corner sequences, random run against a timeline model.
module tb_print_port;

    localparam int HOLD  = 4;
    localparam int GAPC  = 2;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [15:0] wr_data = '0;
    logic        clear = 1'b0;
    logic        wr_ready, print_signal, busy, overflow;
    logic [15:0] data;

    int n_cmp = 0;
    int n_fail = 0;

    print_port #(
        .DATA_W      (16),
        .DEPTH       (DEPTH),
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAPC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .clear        (clear),
        .print_signal (print_signal),
        .data         (data),
        .busy         (busy),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [15:0] wd;
        logic        ps;
        logic [15:0] d;
        logic        rdy;
        logic        bsy;
        logic        ovf;
    } vec_t;

    vec_t tbl[23];

    function automatic vec_t mk(logic we, logic [15:0] wd, logic ps, logic [15:0] d,
                                logic rdy, logic bsy, logic ovf);
        vec_t v;
        v.we = we; v.wd = wd; v.ps = ps; v.d = d; v.rdy = rdy; v.bsy = bsy; v.ovf = ovf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic ps, input logic [15:0] d,
                           input logic rdy, input logic bsy, input logic ovf);
        chk({tag, ".print_signal"}, 32'(print_signal), 32'(ps));
        chk({tag, ".data"},         32'(data),         32'(d));
        chk({tag, ".wr_ready"},     32'(wr_ready),     32'(rdy));
        chk({tag, ".busy"},         32'(busy),         32'(bsy));
        chk({tag, ".overflow"},     32'(overflow),     32'(ovf));
    endtask

    logic [15:0] seen[$];
    logic [15:0] q[$];

    initial begin
        int hi_cnt;
        int last_start;
        bit have;
        logic [15:0] m_data;
        bit m_ovf;
        bit prev_ps;
        bit timed_out;

        // single write then two back-to-back writes
        tbl[0]  = mk(1, 16'hBEEF, 0, 16'h0000, 1, 1, 0);
        tbl[1]  = mk(0, 16'h0000, 1, 16'hBEEF, 1, 1, 0);
        tbl[2]  = mk(0, 16'h0000, 1, 16'hBEEF, 1, 1, 0);
        tbl[3]  = mk(0, 16'h0000, 1, 16'hBEEF, 1, 1, 0);
        tbl[4]  = mk(0, 16'h0000, 1, 16'hBEEF, 1, 1, 0);
        tbl[5]  = mk(0, 16'h0000, 0, 16'hBEEF, 1, 1, 0);
        tbl[6]  = mk(0, 16'h0000, 0, 16'hBEEF, 1, 1, 0);
        tbl[7]  = mk(0, 16'h0000, 0, 16'hBEEF, 1, 0, 0);
        tbl[8]  = mk(1, 16'h0001, 0, 16'hBEEF, 1, 1, 0);
        tbl[9]  = mk(1, 16'h0002, 1, 16'h0001, 1, 1, 0);
        tbl[10] = mk(0, 16'h0000, 1, 16'h0001, 1, 1, 0);
        tbl[11] = mk(0, 16'h0000, 1, 16'h0001, 1, 1, 0);
        tbl[12] = mk(0, 16'h0000, 1, 16'h0001, 1, 1, 0);
        tbl[13] = mk(0, 16'h0000, 0, 16'h0001, 1, 1, 0);
        tbl[14] = mk(0, 16'h0000, 0, 16'h0001, 1, 1, 0);
        tbl[15] = mk(0, 16'h0000, 0, 16'h0001, 1, 1, 0);
        tbl[16] = mk(0, 16'h0000, 1, 16'h0002, 1, 1, 0);
        tbl[17] = mk(0, 16'h0000, 1, 16'h0002, 1, 1, 0);
        tbl[18] = mk(0, 16'h0000, 1, 16'h0002, 1, 1, 0);
        tbl[19] = mk(0, 16'h0000, 1, 16'h0002, 1, 1, 0);
        tbl[20] = mk(0, 16'h0000, 0, 16'h0002, 1, 1, 0);
        tbl[21] = mk(0, 16'h0000, 0, 16'h0002, 1, 1, 0);
        tbl[22] = mk(0, 16'h0000, 0, 16'h0002, 1, 0, 0);

        // reset state
        #12;
        chk_all("reset", 0, 16'h0000, 1, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            wr_en   = tbl[i].we;
            wr_data = tbl[i].wd;
            step();
            chk_all($sformatf("vec%0d", i), tbl[i].ps, tbl[i].d, tbl[i].rdy, tbl[i].bsy, tbl[i].ovf);
        end

        // overflow: fourth write into a full DEPTH=2 queue is dropped
        wr_en = 1; wr_data = 16'h000A; step();
        wr_data = 16'h000B; step();
        chk("ovf.first_shown", 32'(data), 32'h000A);
        wr_data = 16'h000C; step();
        chk("ovf.wr_ready_full", 32'(wr_ready), 32'h0);
        wr_data = 16'h000D; step();
        chk("ovf.flag", 32'(overflow), 32'h1);
        wr_en = 0;
        prev_ps = print_signal;
        timed_out = 1;
        for (int c = 0; c < 60; c++) begin
            step();
            if (print_signal && !prev_ps) seen.push_back(data);
            prev_ps = print_signal;
            if (!busy) begin timed_out = 0; break; end
        end
        chk("ovf.drain_timeout", 32'(timed_out), 32'h0);
        chk("ovf.count", 32'(seen.size()), 32'd2);
        if (seen.size() == 2) begin
            chk("ovf.second", 32'(seen[0]), 32'h000B);
            chk("ovf.third",  32'(seen[1]), 32'h000C);
        end
        chk("ovf.sticky", 32'(overflow), 32'h1);

        // clear in the second SHOW cycle, with a competing write
        wr_en = 1; wr_data = 16'h1111; step();
        wr_en = 0; step();
        chk("clr.shown", 32'(print_signal), 32'h1);
        step();
        clear = 1; wr_en = 1; wr_data = 16'h1234; step();
        clear = 0; wr_en = 0;
        chk_all("clr", 0, 16'h0000, 1, 0, 0);
        hi_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (print_signal || busy) hi_cnt++;
        end
        chk("clr.never_shown", 32'(hi_cnt), 32'd0);

        // asynchronous reset mid-SHOW, between edges
        wr_en = 1; wr_data = 16'h5555; step();
        wr_en = 0; step();
        chk("arst.pre_show", 32'(print_signal), 32'h1);
        step();
        #2 rst_n = 1'b0;
        #1 chk_all("arst", 0, 16'h0000, 1, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wr_en = 1; wr_data = 16'h6666; step();
        wr_en = 0;
        chk("arst.latency0", 32'(print_signal), 32'h0);
        step();
        chk("arst.ps",   32'(print_signal), 32'h1);
        chk("arst.data", 32'(data), 32'h6666);

        // random run against a window-timeline model
        have = 0; last_start = 0; m_data = '0; m_ovf = 0;
        q.delete();
        for (int n = 0; n < 1500; n++) begin
            bit clr_r, we_r, ready, psx, bsyx;
            logic [15:0] wd_r;
            clr_r = (n == 0) || ($urandom_range(0, 99) == 0);
            we_r  = ($urandom_range(0, 9) < 2);
            wd_r  = 16'($urandom);
            clear = clr_r; wr_en = we_r; wr_data = wd_r;
            if (clr_r) begin
                q.delete(); have = 0; m_data = '0; m_ovf = 0;
            end else begin
                ready = (q.size() < DEPTH);
                if (q.size() > 0 && (!have || n - last_start >= HOLD + GAPC + 1)) begin
                    m_data = q.pop_front();
                    last_start = n;
                    have = 1;
                end
                if (we_r) begin
                    if (ready) q.push_back(wd_r);
                    else m_ovf = 1;
                end
            end
            step();
            psx  = have && (n - last_start < HOLD);
            bsyx = (q.size() > 0) || (have && (n - last_start < HOLD + GAPC));
            chk_all($sformatf("rnd%0d", n), psx, m_data, (q.size() < DEPTH), bsyx, m_ovf);
        end
        clear = 0; wr_en = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/print_port.md
# print_port

Upstream feeder for the LED display stage. Accepts 16-bit print writes from the CPU datapath, queues them in a small FIFO, and presents each value on `data` with `print_signal` asserted for a fixed hold time so every printed value is human-visible on the board LEDs. A blank gap separates consecutive values, so repeated identical prints remain distinguishable. The downstream LED stage drives its LEDs with `data` while `print_signal` is high and drives zeros otherwise.

## Interface
- `DATA_W`, 16: print word width; must match the LED stage.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `HOLD_CYCLES`, 50_000_000: cycles `print_signal` stays high per value (0.5 s at 100 MHz); ≥1.
- `GAP_CYCLES`, 10_000_000: blank cycles after each value; ≥0, 0 skips the gap.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `wr_en`  in  1  CPU print request; one word per high cycle.
- `wr_data`  in  DATA_W  word to print.
- `wr_ready`  out  1  FIFO not full; combinational from occupancy.
- `clear`  in  1  synchronous flush.
- `print_signal`  out  1  display-enable to the LED stage; registered.
- `data`  out  DATA_W  value being displayed; registered.
- `busy`  out  1  high when the state is not IDLE or the FIFO is non-empty.
- `overflow`  out  1  sticky flag; set when a write is dropped.

## Operation
- Write acceptance: a write is accepted on an edge where `wr_en && wr_ready && !clear` is true.
- Dropped write: `wr_en && !wr_ready` drops the word and sets `overflow`. `overflow` stays set until `clear` or reset.
- FSM states: IDLE, SHOW, GAP.
  - IDLE: if the FIFO is non-empty, pop the head, load `data`, set `print_signal=1`, load `hold_cnt=HOLD_CYCLES-1`, and go to SHOW.
  - SHOW: decrement `hold_cnt`. At 0, clear `print_signal`. Then go to GAP with `gap_cnt=GAP_CYCLES-1`, or to IDLE if `GAP_CYCLES==0`.
  - GAP: decrement `gap_cnt`. At 0, go to IDLE. `data` holds the last value; `print_signal` is 0.
- IDLE-to-SHOW pop: the pop happens on the edge that leaves IDLE. IDLE is never skipped; the one IDLE cycle between windows is part of the spacing.
- Full FIFO with simultaneous pop: `wr_ready` reflects occupancy before the pop, so the write is rejected. There is no bypass path.
- Simultaneous write and pop on a non-full FIFO: both happen, and occupancy is unchanged.
- `clear` (synchronous, highest priority below reset):
  - FIFO is emptied, state goes to IDLE.
  - `print_signal`, `data`, counters and `overflow` are zeroed.
  - A write in the same cycle is discarded and does not set `overflow`.
- Counter widths: `hold_cnt` is `$clog2(HOLD_CYCLES)` bits, minimum 1; `gap_cnt` likewise. FIFO pointers are `$clog2(DEPTH)` bits and wrap naturally. Occupancy is `$clog2(DEPTH)+1` bits.

## Timing
- Reset values: `print_signal=0`, `data=0`, `overflow=0`, `busy=0`, `wr_ready=1`, state IDLE, FIFO empty, counters 0.
- Mid-operation reset (`rst_n` low): all of the above take effect immediately, asynchronously. Operation restarts on the first edge after `rst_n` deasserts.
- Write-to-display latency: a write accepted at edge E into an empty, idle block reaches IDLE's non-empty check on edge E+1. `print_signal` and `data` are therefore valid from edge E+1.
- Window length: `print_signal` is high for exactly HOLD_CYCLES cycles, followed by GAP_CYCLES low cycles, then one IDLE cycle.
- Period for back-to-back queued values: HOLD_CYCLES+GAP_CYCLES+1 cycles.
- `data` changes only on the IDLE→SHOW edge, on `clear`, or on reset.

## Structure
- Shared package `print_pkg`:
  - `state_t` enum (IDLE, SHOW, GAP).
  - Default constants `PRINT_DATA_W=16`, `PRINT_HOLD_DEFAULT`, `PRINT_GAP_DEFAULT`.
- Sub-module `print_fifo`:
  - Synchronous FIFO parameterised by `DATA_W`/`DEPTH`.
  - Ports: `clk`, `rst_n`, `flush`, `push`, `push_data`, `pop`, `pop_data`, `full`, `empty`, `count`.
  - `pop_data` shows the head combinationally.
- The top level holds the FSM, the two counters, the output registers and the overflow flag.

## Test plan
All scenarios use `HOLD_CYCLES=4`, `GAP_CYCLES=2`, `DEPTH=2`.
- Reset: hold `rst_n` low → `print_signal=0`, `data=0x0000`, `wr_ready=1`, `busy=0`, `overflow=0`.
- Single write: write 0xBEEF at edge 0 → `print_signal=1` and `data=0xBEEF` for cycles 1–4; low for cycles 5–6; IDLE at 7 with `busy=0`; `data` still 0xBEEF.
- Back-to-back writes: 0x0001 then 0x0002 on consecutive edges → windows start at cycles 1 and 8, each 4 cycles high; `data` switches at edge 8.
- Overflow: write 0x0A, 0x0B, 0x0C, 0x0D on consecutive edges →
  - 0x0A is displayed; 0x0B and 0x0C are queued; `wr_ready=0`.
  - 0x0D is dropped and `overflow=1`.
  - Output sequence is 0x0A, 0x0B, 0x0C only.
- Clear: pulse `clear` in cycle 2 of a SHOW window together with `wr_en` (0x1234) →
  - next cycle `print_signal=0`, `data=0`, FIFO empty, `overflow=0`.
  - 0x1234 is never displayed.
- Async reset: drop `rst_n` mid-SHOW, between clock edges → outputs go to reset values before the next edge; a write after release displays normally with latency 1.
